wallace_mul_arbiter: RTL and testbench
======================================

WALLACE_MUL_ARBITER -- requirements
Module: wallace_mul_arbiter

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, 0 = round-robin arbitration, 1 = fixed priority to port 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  port 0 (fmul) operand request.
REQ-005 req0_ready  output  1  port 0 request accepted this cycle when high with req0_valid.
REQ-006 a0  input  24  port 0 multiplicand (significand).
REQ-007 b0  input  26  port 0 multiplier.
REQ-008 req1_valid, req1_ready, a1[23:0], b1[25:0]  as REQ-004..007, port 1 (fdiv/fsqrt iteration).
REQ-009 rsp0_valid  output  1  port 0 product available.
REQ-010 rsp0_ready  input  1  port 0 consumes product this cycle when high with rsp0_valid.
REQ-011 rsp0_z  output  50  port 0 unsigned product a0*b0.
REQ-012 rsp1_valid, rsp1_ready, rsp1_z[49:0]  as REQ-009..011, port 1.
REQ-013 busy  output  1  high while stage 1 or either response register is occupied.

Function
REQ-014 Block shall own one shared 26x24 Wallace-tree multiplier (sum/carry partial product plus final add) and time-share it between ports 0 and 1.
REQ-015 Pipeline: stage 1 = operand register {a, b, tag, s1_valid}; stage 2 = one response register per port {z, rsp_valid}; multiplier is combinational between them.
REQ-016 Accept (handshake) in cycle N shall yield rspX_valid high from cycle N+2 when no stall; throughput one product per cycle.
REQ-017 Product shall be exact unsigned 50-bit a*b, no rounding or truncation.
REQ-018 At most one of req0_ready/req1_ready high in any cycle; readyX asserted only when reqX_valid high and stage 1 can load.
REQ-019 Stage 1 can load when s1_valid=0 or stage 1 advances this cycle.
REQ-020 Stage 1 advances when response register of its tag is empty, or is full with rspX_ready high that cycle (same-cycle drain and refill allowed).
REQ-021 Response register X holds z and rspX_valid stable until rspX_ready; it does not block the other port's traffic except via a stalled stage 1.
REQ-022 Round-robin (PRIO_FIXED=0): pointer rr_last names last granted port; if both valid, grant the other port; if one valid, grant it; rr_last updates only on actual accept.
REQ-023 Fixed priority (PRIO_FIXED=1): port 0 wins whenever both valid.
REQ-024 Request inputs sampled only in accept cycle; later changes to aX/bX shall not affect accepted operation.
REQ-025 No request shall be dropped or duplicated; products for a port return in accept order.
REQ-026 busy = s1_valid | rsp0_valid | rsp1_valid.

Reset
REQ-027 On rst high at a clock edge: s1_valid, rsp0_valid, rsp1_valid = 0, rr_last = 1 (port 0 wins first tie), busy = 0; z registers cleared to 0.
REQ-028 While rst high, req0_ready and req1_ready shall be 0.
REQ-029 Reset mid-operation shall discard in-flight operands and unconsumed products; no rspX_valid after reset until a new accept.

Verification
REQ-030 Single op: port 0 a0=0xFFFFFF, b0=0x3FFFFFF accepted cycle N, rsp0_ready=1 -> rsp0_valid cycle N+2, rsp0_z=0x3FFFFFB000001.
REQ-031 Tie, round-robin: both ports valid for 4 cycles, rsp ready=1 -> grants alternate 0,1,0,1; products 0x000003*0x0000005=15 on port 0, 0x000000*0x3FFFFFF=0 on port 1.
REQ-032 Backpressure: rsp0_ready=0 with rsp0 full, port 0 issues two more requests -> stage 1 holds second, req0_ready=0, port 1 ops still complete; raising rsp0_ready drains in order with no loss.
REQ-033 Fixed priority (PRIO_FIXED=1): both ports valid continuously -> port 1 never granted until req0_valid drops.
REQ-034 Reset mid-flight: accept op, assert rst cycle N+1 -> rsp0_valid, rsp1_valid, busy = 0 at N+2 and stay 0 until next accept.
REQ-035 Random: 10k constrained-random ops with random valid/ready -> every product equals reference a*b, per-port order preserved, readys mutually exclusive.

Source files
------------

// File: rtl/wallace_mul_arbiter.sv
// Two-port arbiter sharing one 24x26 Wallace-tree multiplier.
// Operand register feeds the multiplier; each port has its own response register.
module wallace_mul_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] a0,
    input  logic [25:0] b0,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] a1,
    input  logic [25:0] b1,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [49:0] rsp0_z,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [49:0] rsp1_z,
    output logic        busy
);
    localparam int AW = 24;
    localparam int ZW = 50;

    // Rows are reduced three-at-a-time by 3:2 compressors (24->16->11->8->6->4->3->2),
    // then one carry-propagate add. Arithmetic is mod 2^50, which holds the exact product.
    function automatic logic [ZW-1:0] wallace_mul(input logic [23:0] a, input logic [25:0] b);
        logic [ZW-1:0] row [0:AW-1];
        logic [ZW-1:0] nxt [0:AW-1];
        int n;
        int m;
        for (int i = 0; i < AW; i++)
            row[i] = a[i] ? (ZW'(b) << i) : '0;
        n = AW;
        for (int lvl = 0; lvl < 8; lvl++) begin
            if (n > 2) begin
                m = 0;
                for (int r = 0; r < AW; r++)
                    nxt[r] = '0;
                for (int g = 0; g < 8; g++) begin
                    if (3 * g + 2 < n) begin
                        nxt[m]     = row[3*g] ^ row[3*g+1] ^ row[3*g+2];
                        nxt[m + 1] = ((row[3*g] & row[3*g+1]) | (row[3*g] & row[3*g+2]) |
                                      (row[3*g+1] & row[3*g+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int r = 0; r < AW; r++) begin
                    if (r >= 3 * (n / 3) && r < n) begin
                        nxt[m] = row[r];
                        m = m + 1;
                    end
                end
                row = nxt;
                n = m;
            end
        end
        return row[0] + row[1];
    endfunction

    logic          s1_valid;
    logic          s1_tag;
    logic [23:0]   s1_a;
    logic [25:0]   s1_b;
    logic          rr_last;
    logic          s1_adv;
    logic          s1_open;
    logic          tie_pick1;
    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic [ZW-1:0] prod;

    assign prod    = wallace_mul(s1_a, s1_b);
    assign s1_adv  = s1_valid && (s1_tag ? (!rsp1_valid || rsp1_ready)
                                         : (!rsp0_valid || rsp0_ready));
    assign s1_open = !s1_valid || s1_adv;

    // On a tie, round-robin grants the port not served last; fixed mode always favours port 0.
    assign tie_pick1  = (PRIO_FIXED != 0) ? 1'b0 : !rr_last;
    assign gnt0       = req0_valid && (!req1_valid || !tie_pick1);
    assign gnt1       = req1_valid && (!req0_valid || tie_pick1);
    assign req0_ready = !rst && s1_open && gnt0;
    assign req1_ready = !rst && s1_open && gnt1;
    assign accept     = req0_ready || req1_ready;
    assign busy       = s1_valid || rsp0_valid || rsp1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_tag     <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            rr_last    <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_z     <= '0;
            rsp1_z     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_tag   <= req1_ready;
                s1_a     <= req1_ready ? a1 : a0;
                s1_b     <= req1_ready ? b1 : b0;
                rr_last  <= req1_ready;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            // Drain first so a same-cycle refill wins.
            if (rsp0_valid && rsp0_ready)
                rsp0_valid <= 1'b0;
            if (s1_adv && !s1_tag) begin
                rsp0_valid <= 1'b1;
                rsp0_z     <= prod;
            end

            if (rsp1_valid && rsp1_ready)
                rsp1_valid <= 1'b0;
            if (s1_adv && s1_tag) begin
                rsp1_valid <= 1'b1;
                rsp1_z     <= prod;
            end
        end
    end
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and random traffic
// against a per-port queue model of exact products.
module tb_wallace_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [23:0] a0, a1;
    logic [25:0] b0, b1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [49:0] rsp0_z, rsp1_z;
    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
    logic [49:0] fp_rsp0_z, fp_rsp1_z;

    always #5 clk = ~clk;

    wallace_mul_arbiter #(.PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .a0(a0), .b0(b0),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .a1(a1), .b1(b1),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z),
        .busy(busy)
    );

    wallace_mul_arbiter #(.PRIO_FIXED(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .a0(a0), .b0(b0),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .a1(a1), .b1(b1),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(fp_rsp0_z),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(fp_rsp1_z),
        .busy(fp_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int accepts  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: each accept queues the exact product for its port.
    logic [49:0] q0[$];
    logic [49:0] q1[$];

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_ready || req1_ready) begin
                check("ready_mutex", 64'(req0_ready & req1_ready), 0);
                check("ready_wo_valid", 64'((req0_ready & !req0_valid) | (req1_ready & !req1_valid)), 0);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) check("rsp0_spurious", 1, 0);
                else check("rsp0_z_model", 64'(rsp0_z), 64'(q0.pop_front()));
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) check("rsp1_spurious", 1, 0);
                else check("rsp1_z_model", 64'(rsp1_z), 64'(q1.pop_front()));
            end
            if (req0_valid && req0_ready) begin
                q0.push_back(50'(a0) * 50'(b0));
                accepts++;
            end
            if (req1_valid && req1_ready) begin
                q1.push_back(50'(a1) * 50'(b1));
                accepts++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_req0_ready", 64'(req0_ready), 0);
        check("rst_req1_ready", 64'(req1_ready), 0);
        check("rst_fp_ready", 64'(fp_req0_ready | fp_req1_ready), 0);
        check("rst_rsp_valid", 64'(rsp0_valid | rsp1_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_z", 64'(rsp0_z | rsp1_z), 0);
        cyc();
        rst = 1'b0;
        idle();
    endtask

    task automatic drain(input string name);
        idle();
        for (int i = 0; i < 6; i++) cyc();
        @(negedge clk);
        check(name, 64'(q0.size() + q1.size()), 0);
        check({name, "_busy"}, 64'(busy), 0);
        cyc();
    endtask

    task automatic single(input bit port, input logic [23:0] a, input logic [25:0] b,
                          input logic [49:0] z);
        if (port) begin req1_valid = 1'b1; a1 = a; b1 = b; end
        else      begin req0_valid = 1'b1; a0 = a; b0 = b; end
        @(negedge clk);
        check("vec_ready", 64'(port ? req1_ready : req0_ready), 1);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        a0 = 24'($urandom); b0 = 26'($urandom); a1 = 24'($urandom); b1 = 26'($urandom);
        @(negedge clk);
        check("vec_early", 64'(port ? rsp1_valid : rsp0_valid), 0);
        cyc();
        @(negedge clk);
        check("vec_valid", 64'(port ? rsp1_valid : rsp0_valid), 1);
        check("vec_z", 64'(port ? rsp1_z : rsp0_z), 64'(z));
        cyc();
    endtask

    typedef struct {
        bit          port;
        logic [23:0] a;
        logic [25:0] b;
        logic [49:0] z;
    } vec_t;

    vec_t vecs[9];
    bit   exp_g1[4];
    int   start;
    int   cycles;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 24'hFFFFFF, 26'h3FFFFFF, 50'h3FFFFFB000001};
        vecs[1] = '{1'b1, 24'hFFFFFF, 26'h3FFFFFF, 50'h3FFFFFB000001};
        vecs[2] = '{1'b0, 24'h000003, 26'h0000005, 50'h00000000000F};
        vecs[3] = '{1'b1, 24'h000000, 26'h3FFFFFF, 50'h000000000000};
        vecs[4] = '{1'b0, 24'h000001, 26'h3FFFFFF, 50'h000003FFFFFF};
        vecs[5] = '{1'b1, 24'hFFFFFF, 26'h0000001, 50'h000000FFFFFF};
        vecs[6] = '{1'b0, 24'h800000, 26'h2000000, 50'h1000000000000};
        vecs[7] = '{1'b1, 24'h123456, 26'h0000010, 50'h000001234560};
        vecs[8] = '{1'b0, 24'hFFFFFF, 26'h0000000, 50'h000000000000};
        exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 9; i++)
            single(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].z);
        drain("vec_drain");

        // Round-robin tie: first grant goes to port 0 after reset.
        do_reset();
        req0_valid = 1'b1; a0 = 24'h3; b0 = 26'h5;
        req1_valid = 1'b1; a1 = 24'h0; b1 = 26'h3FFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tie_grant0", 64'(req0_ready), 64'(!exp_g1[i]));
            check("tie_grant1", 64'(req1_ready), 64'(exp_g1[i]));
            cyc();
        end
        drain("tie_drain");

        // Backpressure on port 0.
        do_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; a0 = 24'h11; b0 = 26'h22;
        @(negedge clk); check("bp_acc_a", 64'(req0_ready), 1);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b1; a1 = 24'h5; b1 = 26'h7;
        @(negedge clk); check("bp_acc_p1", 64'(req1_ready), 1);
        cyc();
        req1_valid = 1'b0; req0_valid = 1'b1; a0 = 24'h33; b0 = 26'h44;
        @(negedge clk); check("bp_acc_b", 64'(req0_ready), 1);
        cyc();
        a0 = 24'h55; b0 = 26'h66;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("bp_p1_valid", 64'(rsp1_valid), 1);
                check("bp_p1_z", 64'(rsp1_z), 64'h23);
            end
            check("bp_stall_ready", 64'(req0_ready), 0);
            check("bp_hold_valid", 64'(rsp0_valid), 1);
            check("bp_hold_z", 64'(rsp0_z), 64'h242);
            check("bp_busy", 64'(busy), 1);
            cyc();
        end
        rsp0_ready = 1'b1;
        @(negedge clk); check("bp_release", 64'(req0_ready), 1);
        cyc();
        drain("bp_drain");

        // Fixed priority instance never grants port 1 while port 0 requests.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0 = 24'($urandom); b0 = 26'($urandom); a1 = 24'($urandom); b1 = 26'($urandom);
            @(negedge clk);
            check("fp_grant0", 64'(fp_req0_ready), 1);
            check("fp_no_grant1", 64'(fp_req1_ready), 0);
            cyc();
        end
        req0_valid = 1'b0;
        @(negedge clk); check("fp_grant1_after", 64'(fp_req1_ready), 1);
        cyc();
        drain("fp_drain");

        // Reset while an operation is in flight.
        do_reset();
        req0_valid = 1'b1; a0 = 24'h77; b0 = 26'h99;
        @(negedge clk); check("mid_acc", 64'(req0_ready), 1);
        cyc();
        req0_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_rsp_valid", 64'(rsp0_valid | rsp1_valid), 0);
            check("mid_busy", 64'(busy), 0);
            cyc();
        end

        // Random traffic; operands change every cycle even while held.
        do_reset();
        start = accepts;
        cycles = 0;
        while (accepts - start < 10000 && cycles < 60000) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            a0 = 24'($urandom); b0 = 26'($urandom);
            a1 = 24'($urandom); b1 = 26'($urandom);
            if ($urandom_range(0, 7) == 0) begin a0 = 24'hFFFFFF; b0 = 26'h3FFFFFF; end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            cyc();
            cycles++;
        end
        check("rand_ops_done", 64'(accepts - start >= 10000), 1);
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
